// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: decoded control bundle,
// sequencer state encoding and datapath mux-select codes.
package multicycle_ctrl_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic [1:0] reg_write_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
    } control_signals_t;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_TARGET = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter,
// both wrapping modulo 2^CNT_W and cleared by reset.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I multi-cycle datapath.
// Define PERF_CNT_EN to build the cycle/instret counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  control_signals_t ctrl,
    input  logic             op_valid,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             alu_res_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    ctrl_state_e state, nxt;
    logic        is_mem;
    logic        unused_ctrl;

    assign is_mem      = ctrl.mem_read | ctrl.mem_write;
    assign state_o     = state;
    assign unused_ctrl = ^{ctrl.alu_op, ctrl.reg_write_src, ctrl.mem_size};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RESET;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_RESET:  nxt = S_FETCH;
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: nxt = op_valid ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (is_mem)
                    nxt = S_MEM;
                else if (ctrl.branch)
                    nxt = S_FETCH;
                else
                    nxt = S_WB;
            end
            // a combined read+write access resolves as a store
            S_MEM:    if (mem_ready) nxt = ctrl.mem_write ? S_FETCH : S_WB;
            S_WB:     nxt = S_FETCH;
            default:  nxt = S_RESET;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = ADDR_SEL_PC;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        alu_res_we = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_SEL_PLUS4;
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE: begin
                illegal = ~op_valid;
                pc_we   = ~op_valid;
            end
            S_EXEC: begin
                alu_res_we = 1'b1;
                if (!is_mem && ctrl.branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_ALU;
                mem_we   = ctrl.mem_write;
                mdr_we   = mem_ready & ~ctrl.mem_write;
                pc_we    = mem_ready & ctrl.mem_write;
            end
            S_WB: begin
                rf_we = ctrl.reg_write;
                pc_we = 1'b1;
                if (ctrl.jump)
                    pc_sel = ctrl.alu_src ? PC_SEL_JALR : PC_SEL_TARGET;
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic count_en;
    logic retire;

    assign count_en = (state != S_RESET);
    assign retire   = pc_we & ~illegal;

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .count_en   (count_en),
        .retire     (retire),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output traces built from
// the instruction class, driven with randomized controls and memory waits.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       mdrwe;
        logic       aluwe;
        logic       rfwe;
        logic       pcwe;
        logic [1:0] psel;
        logic       ill;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t o;
    } step_t;

    logic             clk = 1'b0;
    logic             rst;
    control_signals_t ctrl;
    logic             op_valid, branch_taken, mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_we, mdr_we;
    logic             alu_res_we, rf_we, pc_we, illegal;
    logic [1:0]       pc_sel;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    obs_t             act, exp_o, snap;
    step_t            q[$];
    int               nchk = 0;
    int               nerr = 0;
    logic [CNT_W-1:0] m_cyc, m_ret;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .op_valid(op_valid),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .mdr_we(mdr_we), .alu_res_we(alu_res_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    assign act = {state_o, mem_req, mem_we, addr_sel, ir_we, mdr_we,
                  alu_res_we, rf_we, pc_we, pc_sel, illegal};

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Expected per-cycle outputs of one instruction, from its class and waits.
    task automatic build(control_signals_t c, bit ov, bit bt, int fw, int mw);
        step_t s;
        bit    mem = c.mem_read | c.mem_write;
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            s = '0;
            s.o.st = S_FETCH; s.o.req = 1'b1;
            s.rdy = (i == fw); s.o.irwe = (i == fw);
            q.push_back(s);
        end
        s = '0; s.rdy = 1'($urandom); s.o.st = S_DECODE;
        if (!ov) begin
            s.o.ill = 1'b1; s.o.pcwe = 1'b1;
            q.push_back(s);
            return;
        end
        q.push_back(s);
        s = '0; s.rdy = 1'($urandom); s.o.st = S_EXEC; s.o.aluwe = 1'b1;
        if (!mem && c.branch) begin
            s.o.pcwe = 1'b1;
            s.o.psel = bt ? 2'b01 : 2'b00;
            q.push_back(s);
            return;
        end
        q.push_back(s);
        if (mem) begin
            for (int i = 0; i <= mw; i++) begin
                s = '0;
                s.o.st = S_MEM; s.o.req = 1'b1; s.o.asel = 1'b1;
                s.o.we = c.mem_write; s.rdy = (i == mw);
                if (i == mw) begin
                    if (c.mem_write) s.o.pcwe = 1'b1;
                    else s.o.mdrwe = 1'b1;
                end
                q.push_back(s);
            end
            if (c.mem_write) return;
        end
        s = '0; s.rdy = 1'($urandom); s.o.st = S_WB;
        s.o.rfwe = c.reg_write; s.o.pcwe = 1'b1;
        s.o.psel = !c.jump ? 2'b00 : (c.alu_src ? 2'b10 : 2'b01);
        q.push_back(s);
    endtask

    // Compare point: one negedge sample per cycle, then advance past posedge.
    task automatic tick();
        @(negedge clk);
        snap = act;
        nchk++;
        if (act !== exp_o) begin
            nerr++;
            $display("FAIL cycle st=%0d: got %h expected %h", exp_o.st, act, exp_o);
        end
`ifdef PERF_CNT_EN
        nchk++;
        if (cycle_cnt !== m_cyc || instret_cnt !== m_ret) begin
            nerr++;
            $display("FAIL counters: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                     cycle_cnt, instret_cnt, m_cyc, m_ret);
        end
        m_cyc = m_cyc + 1;
        if (exp_o.pcwe && !exp_o.ill) m_ret = m_ret + 1;
`else
        nchk++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            nerr++;
            $display("FAIL counters_tied: got cyc=%0d ret=%0d expected 0 0",
                     cycle_cnt, instret_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic run(control_signals_t c, bit ov, bit bt, int fw, int mw,
                       int abort_at, output int pc_at, output logic [1:0] ps,
                       output int n_mdr, output int n_acc, output int n_rf);
        build(c, ov, bt, fw, mw);
        pc_at = 0; ps = 2'b00; n_mdr = 0; n_acc = 0; n_rf = 0;
        foreach (q[i]) begin
            ctrl         = (q[i].o.st == S_FETCH) ? control_signals_t'(16'($urandom)) : c;
            op_valid     = (q[i].o.st == S_DECODE) ? ov : 1'($urandom);
            branch_taken = (q[i].o.st == S_EXEC) ? bt : 1'($urandom);
            mem_ready    = q[i].rdy;
            exp_o        = q[i].o;
            if (i == abort_at) return;
            tick();
            if (snap.pcwe && pc_at == 0) begin
                pc_at = i + 1;
                ps    = snap.psel;
            end
            n_mdr += int'(snap.mdrwe);
            n_acc += int'(snap.req & snap.asel);
            n_rf  += int'(snap.rfwe);
        end
    endtask

    initial begin
        control_signals_t c;
        int               pa, nm, na, nr;
        logic [1:0]       ps;

        rst = 1'b1; ctrl = '0; op_valid = 1'b0;
        branch_taken = 1'b0; mem_ready = 1'b0;
        m_cyc = '0; m_ret = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(act), 32'd0);
        chk("reset_cycle_cnt", cycle_cnt, 32'd0);
        chk("reset_instret_cnt", instret_cnt, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_state", 32'(state_o), 32'(S_FETCH));
        chk("first_mem_req", 32'(mem_req), 32'd1);
        chk("first_addr_sel", 32'(addr_sel), 32'd0);

        c = '0; c.reg_write = 1'b1;
        run(c, 1, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("add_pc_cycle", pa, 4); chk("add_pc_sel", 32'(ps), 0);
        chk("add_rf", nr, 1);
`ifdef PERF_CNT_EN
        chk("add_instret", instret_cnt, 32'd1);
        chk("add_cycles", cycle_cnt, 32'd4);
`endif

        c = '0; c.mem_read = 1'b1; c.reg_write = 1'b1; c.mem_size = 3'b010;
        run(c, 1, 0, 0, 3, -1, pa, ps, nm, na, nr);
        chk("lw_pc_cycle", pa, 8); chk("lw_mdr_pulses", nm, 1);
        chk("lw_mem_cycles", na, 4); chk("lw_rf", nr, 1);

        c = '0; c.mem_write = 1'b1; c.mem_size = 3'b010;
        run(c, 1, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("sw_pc_cycle", pa, 4); chk("sw_rf", nr, 0);
        chk("sw_pc_sel", 32'(ps), 0);

        c = '0; c.branch = 1'b1;
        run(c, 1, 1, 0, 0, -1, pa, ps, nm, na, nr);
        chk("beq_t_pc_cycle", pa, 3); chk("beq_t_pc_sel", 32'(ps), 1);
        chk("beq_t_rf", nr, 0);
        run(c, 1, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("beq_nt_pc_cycle", pa, 3); chk("beq_nt_pc_sel", 32'(ps), 0);

        c = '0; c.jump = 1'b1; c.reg_write = 1'b1;
        run(c, 1, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("jal_pc_sel", 32'(ps), 1); chk("jal_rf", nr, 1);
        chk("jal_pc_cycle", pa, 4);
        c.alu_src = 1'b1;
        run(c, 1, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("jalr_pc_sel", 32'(ps), 2);

        run(c, 0, 0, 0, 0, -1, pa, ps, nm, na, nr);
        chk("illegal_pc_cycle", pa, 2); chk("illegal_pc_sel", 32'(ps), 0);
`ifdef PERF_CNT_EN
        chk("illegal_instret", instret_cnt, 32'd7);
`endif

        for (int n = 0; n < 300; n++) begin
            c = control_signals_t'(16'($urandom));
            run(c, ($urandom_range(0, 9) != 0), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), -1, pa, ps, nm, na, nr);
        end

        // abort a load while it waits in MEM
        c = '0; c.mem_read = 1'b1; c.reg_write = 1'b1;
        run(c, 1, 0, 0, 3, 4, pa, ps, nm, na, nr);
        #2;
        chk("abort_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outputs", 32'(act), 32'd0);
        chk("abort_cycle_cnt", cycle_cnt, 32'd0);
        chk("abort_instret_cnt", instret_cnt, 32'd0);
        m_cyc = '0; m_ret = '0;
        @(negedge clk) begin rst = 1'b0; mem_ready = 1'b0; end
        @(posedge clk);
        #1;
        chk("abort_state", 32'(state_o), 32'(S_FETCH));
        chk("abort_mem_req", 32'(mem_req), 32'd1);
        chk("abort_addr_sel", 32'(addr_sel), 32'd0);

        for (int n = 0; n < 50; n++) begin
            c = control_signals_t'(16'($urandom));
            run(c, ($urandom_range(0, 9) != 0), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), -1, pa, ps, nm, na, nr);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
